// File: rtl/chan_est_pkg.sv
// Shared definitions for the channel-estimator tap loader and the estimator's
// instruction decode: geometry, instruction encodings and loader FSM states.
package chan_est_pkg;

  localparam int EST_DEPTH    = 30;
  localparam int EST_BITWIDTH = 8;
  localparam int HOLD_CYCLES  = 3;
  localparam int TAP_W        = 5;
  localparam int CNT_W        = $clog2(EST_DEPTH + 1);

  localparam logic [TAP_W-1:0] DEPTH_TAP = TAP_W'(EST_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(EST_DEPTH);

  localparam logic [2:0] CHAN_EST_INST_LOAD = 3'b100;
  localparam logic [2:0] CHAN_EST_INST_NOP  = 3'b000;

  typedef logic signed [EST_BITWIDTH:0]   load_val_t;
  typedef logic signed [EST_BITWIDTH-1:0] tap_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CHECK,
    ST_GAP,
    ST_DONE
  } chan_est_loader_states_t;

  function automatic logic range_ok(logic [TAP_W-1:0] first, logic [TAP_W-1:0] last);
    return (first <= last) && (last < DEPTH_TAP);
  endfunction

endpackage

// File: rtl/chan_est_loader_if.sv
// Instruction/load port between the tap loader (master) and the channel
// estimator (slave), including the estimator's tap readback bus.
interface chan_est_loader_if;
  import chan_est_pkg::*;

  logic             exec_inst;
  logic [2:0]       inst;
  logic [TAP_W-1:0] load_addr;
  load_val_t        load_val;
  tap_t             est_chan [EST_DEPTH];

  modport master (output exec_inst, inst, load_addr, load_val, input est_chan);
  modport slave  (input exec_inst, inst, load_addr, load_val, output est_chan);

endinterface

// File: rtl/chan_est_shadow_buf.sv
// Shadow buffer of initial tap values: gated write port and one combinational
// read port with write-first forwarding.
module chan_est_shadow_buf
  import chan_est_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             busy,
  input  logic [TAP_W-1:0] addr,
  input  load_val_t        wdata,
  input  logic [TAP_W-1:0] rd_addr,
  output load_val_t        rd_data
);

  load_val_t mem [EST_DEPTH];
  logic      wr_ok;

  assign wr_ok = we && !busy && (addr < DEPTH_TAP);

  // NOTE: the array is small and must read back as zero after reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < EST_DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      // NOTE: non-blocking so every reader in this edge sees the old value.
      mem[addr] <= wdata;
    end
  end

  // A write landing on the same edge as a read is forwarded, so a start that
  // coincides with a config write loads the new value.
  always_comb begin
    // NOTE: assign a default first so no path leaves rd_data unassigned (latch).
    rd_data = '0;
    if (wr_ok && (addr == rd_addr)) rd_data = wdata;
    else if (rd_addr < DEPTH_TAP)   rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/chan_est_loader.sv
// Sequences one load instruction per shadow-buffer tap into the channel
// estimator, verifies each write through est_chan, then freezes or releases it.
module chan_est_loader
  import chan_est_pkg::*;
#(
  parameter int hold_cycles = HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [TAP_W-1:0]      cfg_addr,
  input  load_val_t             cfg_val,
  input  logic                  start,
  input  logic [TAP_W-1:0]      first_tap,
  input  logic [TAP_W-1:0]      last_tap,
  input  logic                  freeze,
  chan_est_loader_if.master     est,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  output logic [CNT_W-1:0]      mismatch_cnt
);

  localparam logic [7:0] HOLD_LAST = 8'(hold_cycles - 1);

  chan_est_loader_states_t state;
  logic [TAP_W-1:0]        tap;
  logic [TAP_W-1:0]        last_q;
  logic                    freeze_q;
  logic [7:0]              hold_cnt;
  logic [TAP_W-1:0]        rd_addr;
  load_val_t               rd_data;
  logic                    accepting;

  assign accepting = (state == ST_IDLE) || (state == ST_DONE);
  assign rd_addr   = accepting ? first_tap : tap + 1'b1;

  chan_est_shadow_buf u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .busy    (busy),
    .addr    (cfg_addr),
    .wdata   (cfg_val),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tap           <= '0;
      last_q        <= '0;
      freeze_q      <= 1'b0;
      hold_cnt      <= '0;
      est.exec_inst <= 1'b0;
      est.inst      <= CHAN_EST_INST_NOP;
      est.load_addr <= '0;
      est.load_val  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      range_err     <= 1'b0;
      mismatch_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (!range_ok(first_tap, last_tap)) begin
              // Estimator drive is left as-is: no load is issued.
              range_err <= 1'b1;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              range_err     <= 1'b0;
              mismatch_cnt  <= '0;
              tap           <= first_tap;
              last_q        <= last_tap;
              freeze_q      <= freeze;
              hold_cnt      <= '0;
              busy          <= 1'b1;
              est.exec_inst <= 1'b1;
              est.inst      <= CHAN_EST_INST_LOAD;
              est.load_addr <= first_tap;
              est.load_val  <= rd_data;
              state         <= ST_ISSUE;
            end
          end
        end

        // Held long enough for the estimator to reach execute, load, and park.
        ST_ISSUE: begin
          if (hold_cnt == HOLD_LAST) state    <= ST_CHECK;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end

        ST_CHECK: begin
          if ((est.est_chan[tap] != tap_t'(est.load_val[EST_BITWIDTH-1:0])) &&
              (mismatch_cnt != CNT_MAX))
            mismatch_cnt <= mismatch_cnt + 1'b1;
          est.inst <= CHAN_EST_INST_NOP;
          if (tap == last_q) begin
            est.exec_inst <= freeze_q;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= ST_DONE;
          end else begin
            est.exec_inst <= 1'b0;
            state         <= ST_GAP;
          end
        end

        // One low cycle releases the estimator from halt before the next load.
        ST_GAP: begin
          tap           <= tap + 1'b1;
          hold_cnt      <= '0;
          est.exec_inst <= 1'b1;
          est.inst      <= CHAN_EST_INST_LOAD;
          est.load_addr <= tap + 1'b1;
          est.load_val  <= rd_data;
          state         <= ST_ISSUE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_est_loader.sv
// Randomized self-checking bench: a queue of per-cycle expected outputs built
// from the load-sequence rules, a reactive estimator model, and literal checks.
module tb_chan_est_loader;
  import chan_est_pkg::*;

  typedef struct packed {
    logic       exec;
    logic [2:0] inst;
    logic [4:0] addr;
    logic [8:0] val;
    logic       busy;
    logic       done;
    logic       rerr;
    logic [4:0] mcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  load_val_t  cfg_val = '0;
  logic       start = 1'b0;
  logic [4:0] first_tap = '0;
  logic [4:0] last_tap = '0;
  logic       freeze = 1'b0;
  logic       busy, done, range_err;
  logic [CNT_W-1:0] mismatch_cnt;

  chan_est_loader_if bus ();

  chan_est_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_val      (cfg_val),
    .start        (start),
    .first_tap    (first_tap),
    .last_tap     (last_tap),
    .freeze       (freeze),
    .est          (bus),
    .busy         (busy),
    .done         (done),
    .range_err    (range_err),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic signed [8:0] sh [30];
  exp_t q [$];
  exp_t steady = '0;
  bit   cmp_en = 1'b0;
  int   corrupt_tap = 31;

  // ---------------- bench estimator ----------------
  int est_cnt = 0;
  int est_delay = 3;
  bit est_loaded = 1'b0;

  always @(posedge clk) begin
    if (bus.exec_inst && bus.inst == CHAN_EST_INST_LOAD) begin
      if (!est_loaded) begin
        est_cnt = est_cnt + 1;
        if (est_cnt >= est_delay) begin
          if (int'(bus.load_addr) == corrupt_tap)
            bus.est_chan[bus.load_addr] <= tap_t'(bus.load_val[7:0] ^ 8'h01);
          else
            bus.est_chan[bus.load_addr] <= tap_t'(bus.load_val[7:0]);
          est_loaded = 1'b1;
        end
      end
    end else begin
      est_cnt    = 0;
      est_loaded = 1'b0;
      est_delay  = int'($urandom_range(1, 3));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    exp_t e;
    if (cmp_en) begin
      if (q.size() > 0) e = q.pop_front();
      else              e = steady;
      check("exec_inst", int'(bus.exec_inst), int'(e.exec));
      check("inst", int'(bus.inst), int'(e.inst));
      check("load_addr", int'(bus.load_addr), int'(e.addr));
      check("load_val", int'(bus.load_val), int'($signed(e.val)));
      check("busy", int'(busy), int'(e.busy));
      check("done", int'(done), int'(e.done));
      check("range_err", int'(range_err), int'(e.rerr));
      check("mismatch_cnt", int'(mismatch_cnt), int'(e.mcnt));
    end
  end

  function automatic bit cur_busy();
    if (q.size() > 0) return q[0].busy;
    return steady.busy;
  endfunction

  // Called at posedge+1; write is accepted unless the loader is busy this cycle.
  task automatic cfg_write(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = 5'(a);
    cfg_val  = 9'(v);
    if (a < 30 && !cur_busy()) sh[a] = 9'(v);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic launch(input int f, input int l, input bit frz,
                        input bit sw_en, input int sw_addr, input int sw_val);
    exp_t e;
    int   m;
    start     = 1'b1;
    first_tap = 5'(f);
    last_tap  = 5'(l);
    freeze    = frz;
    if (sw_en) begin
      cfg_we   = 1'b1;
      cfg_addr = 5'(sw_addr);
      cfg_val  = 9'(sw_val);
      if (sw_addr < 30 && !cur_busy()) sh[sw_addr] = 9'(sw_val);
    end
    q.push_back(steady);
    if (f > l || l >= 30) begin
      e      = steady;
      e.done = 1'b1;
      e.rerr = 1'b1;
      q.push_back(e);
    end else begin
      m = 0;
      for (int t = f; t <= l; t++) begin
        e      = '0;
        e.exec = 1'b1;
        e.inst = 3'b100;
        e.addr = 5'(t);
        e.val  = sh[t];
        e.busy = 1'b1;
        e.mcnt = 5'(m);
        for (int k = 0; k <= HOLD_CYCLES; k++) q.push_back(e);
        if (t == corrupt_tap && m < 30) m++;
        if (t != l) begin
          e.exec = 1'b0;
          e.inst = 3'b000;
          e.mcnt = 5'(m);
          q.push_back(e);
        end
      end
      e      = '0;
      e.exec = frz;
      e.addr = 5'(l);
      e.val  = sh[l];
      e.done = 1'b1;
      e.mcnt = 5'(m);
      q.push_back(e);
    end
    steady      = e;
    steady.done = 1'b0;
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  // Returns the cycle (start sample = cycle 0) in which done was seen.
  task automatic wait_done(output int cyc);
    bit got;
    got = 1'b0;
    cyc = 1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run(input int f, input int l, input bit frz, output int cyc);
    launch(f, l, frz, 1'b0, 0, 0);
    wait_done(cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int i = 0; i < 30; i++) sh[i] = '0;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_exec", int'(bus.exec_inst), 0);
    check("reset_mcnt", int'(mismatch_cnt), 0);

    // Single tap, release afterwards.
    cfg_write(5, 37);
    run(5, 5, 1'b0, cyc);
    check("t1_done_cycle", cyc, 5);
    check("t1_exec_after", int'(bus.exec_inst), 0);
    check("t1_mcnt", int'(mismatch_cnt), 0);
    check("t1_est5", int'(bus.est_chan[5]), 37);

    // Full load, frozen afterwards.
    for (int i = 0; i < 30; i++) cfg_write(i, i - 15);
    run(0, 29, 1'b1, cyc);
    check("t2_done_cycle", cyc, 150);
    repeat (3) @(posedge clk); #1;
    check("t2_exec_frozen", int'(bus.exec_inst), 1);
    check("t2_mcnt", int'(mismatch_cnt), 0);
    for (int i = 0; i < 30; i++) check("t2_est", int'(bus.est_chan[i]), i - 15);

    // Corrupted readback on tap 3, then cleared by a fresh start.
    corrupt_tap = 3;
    run(0, 7, 1'b0, cyc);
    check("t3_done_cycle", cyc, 40);
    check("t3_mcnt", int'(mismatch_cnt), 1);
    corrupt_tap = 31;
    run(0, 0, 1'b0, cyc);
    check("t3_mcnt_clear", int'(mismatch_cnt), 0);

    // Illegal ranges.
    run(10, 4, 1'b0, cyc);
    check("t4a_done_cycle", cyc, 1);
    check("t4a_range_err", int'(range_err), 1);
    check("t4a_exec", int'(bus.exec_inst), 0);
    run(0, 30, 1'b0, cyc);
    check("t4b_done_cycle", cyc, 1);
    check("t4b_range_err", int'(range_err), 1);

    // Writes while busy and to an out-of-range address are dropped.
    cfg_write(2, -50);
    fork
      run(0, 3, 1'b0, cyc);
      begin
        repeat (6) @(posedge clk); #1;
        cfg_write(2, 77);
      end
    join
    cfg_write(31, 5);
    run(2, 2, 1'b0, cyc);
    check("t5_load_val", int'(bus.load_val), -50);
    check("t5_est2", int'(bus.est_chan[2]), -50);

    // Write coinciding with start is used by that sequence.
    launch(4, 4, 1'b0, 1'b1, 4, -100);
    wait_done(cyc);
    check("t6_load_val", int'(bus.load_val), -100);
    check("t6_est4", int'(bus.est_chan[4]), -100);

    // Asynchronous reset during ISSUE of tap 7.
    launch(7, 9, 1'b1, 1'b0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    q.delete();
    steady = '0;
    for (int i = 0; i < 30; i++) sh[i] = '0;
    #1;
    check("rst_exec", int'(bus.exec_inst), 0);
    check("rst_inst", int'(bus.inst), 0);
    check("rst_addr", int'(bus.load_addr), 0);
    check("rst_val", int'(bus.load_val), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(7, 7, 1'b0, cyc);
    check("t7_done_cycle", cyc, 5);
    check("t7_est7", int'(bus.est_chan[7]), 0);

    // Randomized sequences.
    for (int it = 0; it < 12; it++) begin
      int f, l;
      for (int w = 0; w < 4; w++)
        cfg_write(int'($urandom_range(0, 31)), int'($urandom_range(0, 511)) - 256);
      if ($urandom_range(0, 4) == 0) begin
        f = int'($urandom_range(0, 31));
        l = int'($urandom_range(0, 31));
      end else begin
        f = int'($urandom_range(0, 29));
        l = f + int'($urandom_range(0, 4));
        if (l > 29) l = 29;
      end
      corrupt_tap = int'($urandom_range(0, 31));
      launch(f, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 511)) - 256);
      wait_done(cyc);
      if (f <= l && l < 30) check("rand_done_cycle", cyc, (l - f + 1) * (HOLD_CYCLES + 2));
      else                  check("rand_range_err", int'(range_err), 1);
    end
    corrupt_tap = 31;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/chan_est_loader.md
# chan_est_loader

Instruction-side master for the channel estimator's load port. It holds a shadow buffer of initial tap values written by configuration logic. On `start` it sequences one load instruction per tap over the estimator's `exec_inst`/`inst`/`load_addr`/`load_val` interface, then reads back `est_chan` to confirm each write. It sits between the JTAG/config register block and the channel estimator, and can leave the estimator frozen (held in its halt state) or release it to resume adaptation.

## Interface
- `est_depth`, 30, number of taps, both shadow-buffer entries and `est_chan` entries
- `est_bitwidth`, 8, width of `est_chan` taps; load values are `est_bitwidth+1` bits signed
- `hold_cycles`, 3, cycles `exec_inst` is held per load before readback; legal minimum is 3
- `clk`  input  1  sole clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `cfg_we`  input  1  shadow-buffer write strobe
- `cfg_addr`  input  5  shadow-buffer write address
- `cfg_val`  input  signed `est_bitwidth+1`  shadow-buffer write data
- `start`  input  1  begin load sequence; level-sampled in IDLE/DONE only
- `first_tap`, `last_tap`  input  5 each  inclusive tap range, sampled with `start`
- `freeze`  input  1  keep the estimator halted after the sequence; sampled with `start`
- `est_chan`  input  signed `est_bitwidth` × `est_depth`  estimator tap outputs (readback)
- `exec_inst`  output  1  estimator execute request
- `inst`  output  3  estimator instruction; 3'b100 means load
- `load_addr`  output  5  estimator load address
- `load_val`  output  signed `est_bitwidth+1`  estimator load value
- `busy`  output  1  sequence in progress
- `done`  output  1  one-cycle completion pulse
- `range_err`  output  1  sticky until the next accepted `start`: illegal range requested
- `mismatch_cnt`  output  `$clog2(est_depth+1)`  readback mismatches, saturating at `est_depth`

## Operation
- Shadow buffer: `est_depth` signed registers, reset 0. A `cfg_we` write with `cfg_addr<est_depth` and `busy=0` updates the entry. Writes while busy, or to out-of-range addresses, are dropped.
- States: IDLE, ISSUE, CHECK, GAP, DONE.
- IDLE/DONE with `start=1`:
  - Illegal range (`first_tap>last_tap` or `last_tap>=est_depth`): set `range_err`, pulse `done` next cycle, issue no loads.
  - Legal range: clear `range_err` and `mismatch_cnt`, latch range and `freeze`, set `tap=first_tap`, go to ISSUE.
- ISSUE: `exec_inst=1`, `inst=3'b100`, `load_addr=tap`, `load_val=shadow[tap]`, all registered and stable. Lasts `hold_cycles` cycles, then CHECK.
  - Rationale: the estimator may take up to 2 cycles to reach its execute state, loads on the following edge, then parks in halt while `exec_inst` stays high.
- CHECK (1 cycle): outputs unchanged. Compare `est_chan[tap]` with `load_val[est_bitwidth-1:0]`; on inequality, increment `mismatch_cnt` (saturating).
  - If `tap==last_tap`, go to DONE.
  - Otherwise go to GAP.
- GAP (1 cycle): `exec_inst=0`, `inst=3'b000`. This releases the estimator from halt so the next assertion is seen. Then `tap++` and return to ISSUE.
- DONE: `done=1` for the entry cycle only; `busy=0`.
  - `freeze=1`: `exec_inst=1`, `inst=3'b000`, so the estimator stays halted with no load.
  - `freeze=0`: `exec_inst=0`, so adaptation resumes.
  - DONE accepts `start` like IDLE.
- `busy=1` in ISSUE, CHECK and GAP.
- Simultaneous `cfg_we` and `start` in IDLE: the write lands first, so the sequence uses the new value.

## Timing
- Reset values: `exec_inst=0`, `inst=0`, `load_addr=0`, `load_val=0`, `busy=0`, `done=0`, `range_err=0`, `mismatch_cnt=0`, state IDLE.
- `start` sampled in cycle 0; ISSUE begins cycle 1.
- Per tap: `hold_cycles+1` cycles with `exec_inst` high, plus 1 GAP cycle between taps.
- `done` asserts in cycle `N*(hold_cycles+2)` for N taps. For N=30 and `hold_cycles=3`, that is cycle 150.
- Reset mid-sequence: all outputs return to reset values asynchronously. The shadow buffer is also cleared.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `chan_est_pkg`:
  - state enum `chan_est_loader_states_t`
  - `CHAN_EST_INST_LOAD=3'b100`
  - `CHAN_EST_INST_NOP=3'b000`
  - these constants are shared with the estimator's instruction decode
- One sub-module, `chan_est_shadow_buf`: the register array with write port, gating and a single combinational read port.

## Test plan
- Write shadow[5]=9'sd37; start with first=last=5, freeze=0; bench estimator loads correctly → `exec_inst` high cycles 1–4, low from cycle 5, `done` in cycle 5, `mismatch_cnt=0`, `est_chan[5]=37`.
- Full load taps 0..29 with shadow[i]=i-15, freeze=1 → `done` at cycle 150, `exec_inst` remains 1, every `est_chan[i]=i-15`, `mismatch_cnt=0`.
- Bench estimator corrupts tap 3 in range 0..7 → `mismatch_cnt=1` at `done`; a new start clears it to 0.
- Start with first=10, last=4, then with last=30 → no `exec_inst` assertion, `done` next cycle, `range_err=1` each time.
- `cfg_we` to addr 2 during busy, and to addr 31 while idle → shadow unchanged (readback via a load of tap 2 shows the old value).
- Deassert `rst_n` during ISSUE of tap 7 → all outputs reset immediately, state IDLE, a subsequent start runs normally.
